// File: rtl/spi_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl_pkg
// Shared definitions for the SPI frame controller:
//   - FSM state encoding
//   - header byte field positions
//   - status byte signature nibble
// -----------------------------------------------------------------------------
package spi_frame_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DATA  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   // Header byte layout: [7] rw, [6] tgt, [5] reserved, [4:0] len-1
   localparam int HDR_RW      = 7;
   localparam int HDR_TGT     = 6;
   localparam int HDR_RSV     = 5;
   localparam int HDR_LEN_MSB = 4;

   // Low nibble of every status byte, lets the host spot a live controller
   localparam logic [3:0] STATUS_SIG = 4'hA;

endpackage

// File: rtl/spi_cfg_regfile.sv
// -----------------------------------------------------------------------------
// spi_cfg_regfile
// N_REGS x 8-bit configuration register bank.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata single write port, written on the rising edge
//   raddr, rdata     combinational read port
//   regs_flat        whole bank, reg i at bits [8i+7:8i]
// -----------------------------------------------------------------------------
module spi_cfg_regfile #(
   parameter int N_REGS = 8,
   parameter int AW     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [7:0]            wdata,
   input  logic [AW-1:0]         raddr,
   output logic [7:0]            rdata,
   output logic [8*N_REGS-1:0]   regs_flat
);

   logic [7:0] mem_reg [N_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REGS; i++) begin
            mem_reg[i] <= 8'h00;
         end
      end else if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

   for (genvar gi = 0; gi < N_REGS; gi++) begin : g_flat
      assign regs_flat[8*gi +: 8] = mem_reg[gi];
   end

endmodule

// File: rtl/spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl
// Frame-level sequencer sitting above SPI_COMM. Parses header / address /
// payload from EoB-strobed bytes, writes or reads the config register bank,
// streams sniffer FIFO bytes to the host and raises err_in on protocol errors.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   spi_busy/eob/rx_data/err status and received byte from SPI_COMM
//   spi_tx_data, spi_err_req next byte to shift out, error request
//   fifo_data/empty, fifo_rd first-word-fall-through sniffer FIFO
//   cfg_regs                 flattened register bank
//   frame_active             high in any state other than IDLE
// -----------------------------------------------------------------------------
module spi_frame_ctrl
   import spi_frame_ctrl_pkg::*;
#(
   parameter int N_REGS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_busy,
   input  logic                  spi_eob,
   input  logic [7:0]            spi_rx_data,
   input  logic                  spi_err,
   output logic [7:0]            spi_tx_data,
   output logic                  spi_err_req,
   input  logic [7:0]            fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   output logic [8*N_REGS-1:0]   cfg_regs,
   output logic                  frame_active
);

   localparam int AW = $clog2(N_REGS);

   state_t        state_reg, state_next;
   logic [7:0]    tx_reg, tx_next;
   logic          rw_reg, rw_next;
   logic          tgt_reg, tgt_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [5:0]    count_reg, count_next;
   logic          err_sticky_reg, err_sticky_next;
   logic          under_sticky_reg, under_sticky_next;
   logic          trunc_sticky_reg, trunc_sticky_next;

   logic          reg_we;
   logic          load_fifo;
   logic          fifo_pop;
   logic          to_err;
   logic [AW-1:0] rf_raddr;
   logic [7:0]    rf_rdata;
   logic [7:0]    status_byte;

   // In ADDR the first read element is addressed straight from the incoming
   // byte; in DATA the element after the current address is prefetched.
   assign rf_raddr = (state_reg == ST_ADDR) ? spi_rx_data[AW-1:0] : addr_reg + 1'b1;

   spi_cfg_regfile #(.N_REGS(N_REGS), .AW(AW)) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .we        (reg_we & ~rst),
      .waddr     (addr_reg),
      .wdata     (spi_rx_data),
      .raddr     (rf_raddr),
      .rdata     (rf_rdata),
      .regs_flat (cfg_regs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         tx_reg           <= 8'h00;
         rw_reg           <= 1'b0;
         tgt_reg          <= 1'b0;
         addr_reg         <= '0;
         count_reg        <= '0;
         err_sticky_reg   <= 1'b0;
         under_sticky_reg <= 1'b0;
         trunc_sticky_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         tx_reg           <= tx_next;
         rw_reg           <= rw_next;
         tgt_reg          <= tgt_next;
         addr_reg         <= addr_next;
         count_reg        <= count_next;
         err_sticky_reg   <= err_sticky_next;
         under_sticky_reg <= under_sticky_next;
         trunc_sticky_reg <= trunc_sticky_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      tx_next           = tx_reg;
      rw_next           = rw_reg;
      tgt_next          = tgt_reg;
      addr_next         = addr_reg;
      count_next        = count_reg;
      err_sticky_next   = err_sticky_reg;
      under_sticky_next = under_sticky_reg;
      trunc_sticky_next = trunc_sticky_reg;
      reg_we            = 1'b0;
      load_fifo         = 1'b0;
      fifo_pop          = 1'b0;
      to_err            = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            tx_next = 8'h00;
            if (spi_busy) state_next = ST_HDR;
         end
         ST_HDR: begin
            if (spi_eob) begin
               err_sticky_next   = 1'b0;
               under_sticky_next = 1'b0;
               trunc_sticky_next = 1'b0;
               rw_next    = spi_rx_data[HDR_RW];
               tgt_next   = spi_rx_data[HDR_TGT];
               count_next = {1'b0, spi_rx_data[HDR_LEN_MSB:0]} + 6'd1;
               if (spi_rx_data[HDR_RSV] || (spi_rx_data[HDR_TGT] && !spi_rx_data[HDR_RW])) begin
                  state_next = ST_ERR;
                  to_err     = 1'b1;
               end else if (!spi_rx_data[HDR_TGT]) begin
                  state_next = ST_ADDR;
                  tx_next    = 8'h00;
               end else begin
                  state_next = ST_DATA;
                  load_fifo  = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (spi_eob) begin
               if (spi_rx_data > 8'(N_REGS - 1)) begin
                  state_next = ST_ERR;
                  to_err     = 1'b1;
               end else begin
                  addr_next  = spi_rx_data[AW-1:0];
                  state_next = ST_DATA;
                  if (rw_reg) tx_next = rf_rdata;
               end
            end
         end
         ST_DATA: begin
            if (spi_eob) begin
               if (!rw_reg) begin
                  reg_we = 1'b1;
               end else if (count_reg != 6'd1) begin
                  // Never fetch beyond the last payload byte
                  if (tgt_reg) load_fifo = 1'b1;
                  else         tx_next   = rf_rdata;
               end
               addr_next  = addr_reg + 1'b1;
               count_next = count_reg - 6'd1;
               if (count_reg == 6'd1) begin
                  state_next = ST_DRAIN;
                  tx_next    = 8'h00;
               end
            end
         end
         ST_DRAIN: begin
            tx_next = 8'h00;
            if (!spi_busy) state_next = ST_IDLE;
         end
         ST_ERR: begin
            tx_next = 8'h00;
            if (!spi_busy) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // SPI_COMM-reported error aborts whatever the byte would have done
      if (spi_err && state_reg != ST_IDLE && state_reg != ST_ERR) begin
         state_next = ST_ERR;
         to_err     = 1'b1;
         reg_we     = 1'b0;
         load_fifo  = 1'b0;
         tx_next    = 8'h00;
      end

      if (load_fifo) begin
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            tx_next  = fifo_data;
         end else begin
            tx_next           = 8'h00;
            under_sticky_next = 1'b1;
         end
      end

      // Busy fall is applied after any coincident EoB has been processed; it
      // only counts as truncation when the payload was not yet complete.
      if (!spi_busy && (state_reg inside {ST_HDR, ST_ADDR, ST_DATA})) begin
         if (state_next != ST_DRAIN && state_next != ST_ERR) trunc_sticky_next = 1'b1;
         state_next = ST_IDLE;
         tx_next    = 8'h00;
      end

      if (to_err || state_reg == ST_ERR) err_sticky_next = 1'b1;
   end

   assign status_byte  = {err_sticky_reg, under_sticky_reg, trunc_sticky_reg, fifo_empty, STATUS_SIG};
   assign spi_tx_data  = (state_reg == ST_HDR) ? status_byte : tx_reg;
   assign spi_err_req  = (state_reg == ST_ERR);
   assign frame_active = (state_reg != ST_IDLE);
   assign fifo_rd      = fifo_pop & ~rst;

endmodule
